mem_channel_arbiter: RTL and testbench

Round-robin arbiter that shares one data-memory channel among `NUM_CONSUMERS` load/store requesters, such as a single core's LSUs or a debug port. It accepts read and write requests using the codebase's valid/ready consumer protocol. It forwards one transaction at a time to the memory side and relays the response back to the granted requester. Fairness is strict rotating priority, so no requester starves.

---
 rtl/mem_channel_arbiter_if.sv | 47 ++++
 rtl/mem_channel_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_channel_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_channel_arbiter_if.sv
// rtl/mem_channel_arbiter_if.sv - consumer and memory handshake bundle for mem_channel_arbiter
// master is the arbiter's view; slave is the requesters plus the memory.
interface mem_channel_arbiter_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8
);
  logic [NUM_CONSUMERS-1:0] consumer_read_valid;
  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] consumer_read_ready;
  logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] consumer_write_valid;
  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] consumer_write_ready;

  logic                     mem_read_valid;
  logic [ADDR_BITS-1:0]     mem_read_address;
  logic                     mem_read_ready;
  logic [DATA_BITS-1:0]     mem_read_data;
  logic                     mem_write_valid;
  logic [ADDR_BITS-1:0]     mem_write_address;
  logic [DATA_BITS-1:0]     mem_write_data;
  logic                     mem_write_ready;

  modport master (
    input  consumer_read_valid, consumer_read_address,
    output consumer_read_ready, consumer_read_data,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_write_ready,
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
    input  consumer_read_ready, consumer_read_data,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/mem_channel_arbiter.sv
// rtl/mem_channel_arbiter.sv - round-robin arbiter sharing one memory channel among N requesters
// One transaction in flight; rotating priority starts just after the last granted consumer.
module mem_channel_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int WRITE_ENABLE  = 1,
  localparam int IDX_BITS     = $clog2(NUM_CONSUMERS)
) (
  input  logic                clk,
  input  logic                reset,
  mem_channel_arbiter_if.master bus,
  output logic                busy,
  output logic [IDX_BITS-1:0] owner
);
  localparam logic WR_EN = (WRITE_ENABLE != 0);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_BITS-1:0]      owner_q, owner_d;
  logic                     mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]     mem_read_address_q, mem_read_address_d;
  logic                     mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]     mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0]     mem_write_data_q, mem_write_data_d;
  logic [NUM_CONSUMERS-1:0] read_ready_q, read_ready_d;
  logic [NUM_CONSUMERS-1:0] write_ready_q, write_ready_d;
  logic [DATA_BITS-1:0]     read_data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     read_data_d [NUM_CONSUMERS];

  logic                     grant_found;
  logic                     grant_is_read;
  logic [IDX_BITS-1:0]      grant_idx;
  logic [IDX_BITS-1:0]      cand;

  // Scan from owner+1 wrapping; the owner itself is the last candidate.
  always_comb begin
    grant_found   = 1'b0;
    grant_is_read = 1'b0;
    grant_idx     = owner_q;
    cand          = owner_q;
    for (int i = 1; i <= NUM_CONSUMERS; i++) begin
      cand = IDX_BITS'((int'(owner_q) + i) % NUM_CONSUMERS);
      if (!grant_found && bus.consumer_read_valid[cand]) begin
        grant_found   = 1'b1;
        grant_is_read = 1'b1;
        grant_idx     = cand;
      end else if (!grant_found && WR_EN && bus.consumer_write_valid[cand]) begin
        grant_found   = 1'b1;
        grant_is_read = 1'b0;
        grant_idx     = cand;
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    owner_d             = owner_q;
    mem_read_valid_d    = mem_read_valid_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_valid_d   = mem_write_valid_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    read_ready_d        = read_ready_q;
    write_ready_d       = write_ready_q;
    read_data_d         = read_data_q;

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          owner_d = grant_idx;
          if (grant_is_read) begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = bus.consumer_read_address[grant_idx];
            state_d            = READ_WAITING;
          end else begin
            mem_write_valid_d   = 1'b1;
            mem_write_address_d = bus.consumer_write_address[grant_idx];
            mem_write_data_d    = bus.consumer_write_data[grant_idx];
            state_d             = WRITE_WAITING;
          end
        end
      end
      READ_WAITING: begin
        if (bus.mem_read_ready) begin
          mem_read_valid_d      = 1'b0;
          read_data_d[owner_q]  = bus.mem_read_data;
          read_ready_d[owner_q] = 1'b1;
          state_d               = READ_RELAYING;
        end
      end
      WRITE_WAITING: begin
        if (bus.mem_write_ready) begin
          mem_write_valid_d      = 1'b0;
          write_ready_d[owner_q] = 1'b1;
          state_d                = WRITE_RELAYING;
        end
      end
      READ_RELAYING: begin
        if (!bus.consumer_read_valid[owner_q]) begin
          read_ready_d[owner_q] = 1'b0;
          state_d               = IDLE;
        end
      end
      WRITE_RELAYING: begin
        if (!bus.consumer_write_valid[owner_q]) begin
          write_ready_d[owner_q] = 1'b0;
          state_d                = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= IDLE;
      owner_q             <= IDX_BITS'(NUM_CONSUMERS - 1);
      mem_read_valid_q    <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      read_ready_q        <= '0;
      write_ready_q       <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) read_data_q[i] <= '0;
    end else begin
      state_q             <= state_d;
      owner_q             <= owner_d;
      mem_read_valid_q    <= mem_read_valid_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_valid_q   <= mem_write_valid_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      read_ready_q        <= read_ready_d;
      write_ready_q       <= write_ready_d;
      read_data_q         <= read_data_d;
    end
  end

  // With writes disabled the write outputs are tied off, not merely never set.
  assign bus.mem_read_valid       = mem_read_valid_q;
  assign bus.mem_read_address     = mem_read_address_q;
  assign bus.mem_write_valid      = WR_EN & mem_write_valid_q;
  assign bus.mem_write_address    = WR_EN ? mem_write_address_q : '0;
  assign bus.mem_write_data       = WR_EN ? mem_write_data_q : '0;
  assign bus.consumer_read_ready  = read_ready_q;
  assign bus.consumer_write_ready = WR_EN ? write_ready_q : '0;

  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_read_data
    assign bus.consumer_read_data[g] = read_data_q[g];
  end

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// tb/tb_mem_channel_arbiter.sv - self-checking bench for mem_channel_arbiter
// Directed steps then random traffic, each grant predicted by a distance-from-owner model.
module tb_mem_channel_arbiter;
  localparam int N  = 8;
  localparam int AB = 8;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_channel_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N)) bus ();
  mem_channel_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N)) bus_nw ();

  logic       busy, busy_nw;
  logic [2:0] owner, owner_nw;

  mem_channel_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N), .WRITE_ENABLE(1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .owner(owner)
  );

  mem_channel_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N), .WRITE_ENABLE(0)) dut_nw (
    .clk(clk), .reset(reset), .bus(bus_nw), .busy(busy_nw), .owner(owner_nw)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit         req_rd [N];
  bit         req_wr [N];
  logic [7:0] rd_addr_m [N];
  logic [7:0] wr_addr_m [N];
  logic [7:0] wr_data_m [N];
  logic [7:0] rd_data_m [N];
  int         owner_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] oh(input int c);
    logic [7:0] one;
    one = 8'd1;
    return one << c;
  endfunction

  // Winner is the requester at the smallest forward distance past the previous owner.
  function automatic int pick(output bit is_rd);
    int best  = -1;
    int bestd = N;
    is_rd = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (req_rd[c] || req_wr[c]) begin
        int d = (c - owner_m - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = c;
          is_rd = req_rd[c];
        end
      end
    end
    return best;
  endfunction

  task automatic set_rd(input int c, input logic [7:0] a);
    req_rd[c] = 1'b1;
    rd_addr_m[c] = a;
    bus.consumer_read_valid[c] = 1'b1;
    bus.consumer_read_address[c] = a;
  endtask

  task automatic set_wr(input int c, input logic [7:0] a, input logic [7:0] d);
    req_wr[c] = 1'b1;
    wr_addr_m[c] = a;
    wr_data_m[c] = d;
    bus.consumer_write_valid[c] = 1'b1;
    bus.consumer_write_address[c] = a;
    bus.consumer_write_data[c] = d;
  endtask

  task automatic drop(input int c, input bit is_rd);
    if (is_rd) begin
      req_rd[c] = 1'b0;
      bus.consumer_read_valid[c] = 1'b0;
    end else begin
      req_wr[c] = 1'b0;
      bus.consumer_write_valid[c] = 1'b0;
    end
  endtask

  task automatic serve_one(input int lat, input int hold, input bit violate, input logic [7:0] rdata);
    int w;
    bit is_rd;
    w = pick(is_rd);
    if (w < 0) return;
    tick();
    check("grant_rd_valid", bus.mem_read_valid, is_rd);
    check("grant_wr_valid", bus.mem_write_valid, !is_rd);
    check("grant_owner", owner, w);
    check("grant_busy", busy, 1);
    if (is_rd) begin
      check("grant_rd_addr", bus.mem_read_address, rd_addr_m[w]);
      bus.consumer_read_address[w] = rd_addr_m[w] ^ 8'hFF;
    end else begin
      check("grant_wr_addr", bus.mem_write_address, wr_addr_m[w]);
      check("grant_wr_data", bus.mem_write_data, wr_data_m[w]);
      bus.consumer_write_data[w] = wr_data_m[w] ^ 8'hFF;
    end
    if (violate) drop(w, is_rd);
    repeat (lat) begin
      tick();
      check("wait_rd_ready", bus.consumer_read_ready, 0);
      check("wait_wr_ready", bus.consumer_write_ready, 0);
      check("wait_mem_valid", is_rd ? bus.mem_read_valid : bus.mem_write_valid, 1);
    end
    bus.mem_read_data = rdata;
    if (is_rd) bus.mem_read_ready = 1'b1;
    else bus.mem_write_ready = 1'b1;
    tick();
    if (is_rd) begin
      rd_data_m[w] = rdata;
      check("resp_rd_ready", bus.consumer_read_ready, oh(w));
      check("resp_rd_data", bus.consumer_read_data[w], rdata);
      check("resp_mem_rd_valid", bus.mem_read_valid, 0);
      check("resp_rd_addr_held", bus.mem_read_address, rd_addr_m[w]);
      check("resp_wr_ready", bus.consumer_write_ready, 0);
    end else begin
      check("resp_wr_ready", bus.consumer_write_ready, oh(w));
      check("resp_mem_wr_valid", bus.mem_write_valid, 0);
      check("resp_wr_data_held", bus.mem_write_data, wr_data_m[w]);
      check("resp_rd_ready", bus.consumer_read_ready, 0);
    end
    bus.mem_read_ready = 1'b0;
    bus.mem_write_ready = 1'b0;
    bus.mem_read_data = 8'($urandom);
    if (!violate) begin
      repeat (hold) begin
        tick();
        check("hold_ready", is_rd ? bus.consumer_read_ready : bus.consumer_write_ready, oh(w));
        check("hold_busy", busy, 1);
      end
      drop(w, is_rd);
    end
    tick();
    check("end_rd_ready", bus.consumer_read_ready, 0);
    check("end_wr_ready", bus.consumer_write_ready, 0);
    check("end_busy", busy, 0);
    owner_m = w;
  endtask

  initial begin
    reset = 1'b1;
    bus.mem_read_ready = 1'b0;
    bus.mem_write_ready = 1'b0;
    bus.mem_read_data = '0;
    bus_nw.mem_read_ready = 1'b0;
    bus_nw.mem_write_ready = 1'b0;
    bus_nw.mem_read_data = '0;
    bus_nw.consumer_read_valid = '0;
    bus_nw.consumer_write_valid = '0;
    for (int c = 0; c < N; c++) begin
      bus_nw.consumer_read_address[c] = '0;
      bus_nw.consumer_write_address[c] = '0;
      bus_nw.consumer_write_data[c] = '0;
      req_rd[c] = 1'b0;
      req_wr[c] = 1'b0;
      rd_data_m[c] = '0;
    end

    // Reset held two cycles under random inputs
    repeat (2) begin
      bus.consumer_read_valid = 8'($urandom);
      bus.consumer_write_valid = 8'($urandom);
      bus.mem_read_ready = 1'($urandom);
      bus.mem_write_ready = 1'($urandom);
      bus.mem_read_data = 8'($urandom);
      for (int c = 0; c < N; c++) begin
        bus.consumer_read_address[c] = 8'($urandom);
        bus.consumer_write_address[c] = 8'($urandom);
        bus.consumer_write_data[c] = 8'($urandom);
      end
      tick();
    end
    check("rst_mem_rd_valid", bus.mem_read_valid, 0);
    check("rst_mem_wr_valid", bus.mem_write_valid, 0);
    check("rst_mem_rd_addr", bus.mem_read_address, 0);
    check("rst_mem_wr_addr", bus.mem_write_address, 0);
    check("rst_mem_wr_data", bus.mem_write_data, 0);
    check("rst_rd_ready", bus.consumer_read_ready, 0);
    check("rst_wr_ready", bus.consumer_write_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 7);
    for (int c = 0; c < N; c++) check("rst_rd_data", bus.consumer_read_data[c], 0);
    bus.consumer_read_valid = '0;
    bus.consumer_write_valid = '0;
    bus.mem_read_ready = 1'b0;
    bus.mem_write_ready = 1'b0;
    reset = 1'b0;
    owner_m = N - 1;
    tick();

    // Round-robin over all eight readers, then consumer 0 again
    for (int c = 0; c < N; c++) set_rd(c, 8'(8'h40 + c));
    for (int i = 0; i < N; i++) begin
      serve_one(1, 0, 1'b0, 8'(8'hA0 + i));
      check("rr_order", owner, i);
    end
    set_rd(0, 8'h77);
    serve_one(0, 0, 1'b0, 8'h33);
    check("rr_wrap", owner, 0);

    // Single read: consumer 3, address 0x2A, data 0x5C after 3 cycles
    set_rd(3, 8'h2A);
    serve_one(3, 1, 1'b0, 8'h5C);
    check("single_rd_data", bus.consumer_read_data[3], 8'h5C);

    // Read wins over write from the same consumer; write comes on the next lap
    set_rd(2, 8'h10);
    set_wr(2, 8'h20, 8'h99);
    serve_one(1, 0, 1'b0, 8'h11);
    check("prec_read_first", req_wr[2], 1);
    serve_one(2, 0, 1'b0, 8'h00);
    check("prec_write_owner", owner, 2);

    // Valid dropped while waiting: ready pulses once
    set_rd(4, 8'h55);
    serve_one(2, 0, 1'b1, 8'hE7);

    // Memory ready while idle is ignored
    bus.mem_read_ready = 1'b1;
    bus.mem_write_ready = 1'b1;
    repeat (2) begin
      tick();
      check("idle_ready_busy", busy, 0);
      check("idle_ready_rd_ready", bus.consumer_read_ready, 0);
      check("idle_ready_wr_ready", bus.consumer_write_ready, 0);
    end
    bus.mem_read_ready = 1'b0;
    bus.mem_write_ready = 1'b0;

    // Writes disabled instance ignores write requests
    bus_nw.consumer_write_valid[1] = 1'b1;
    bus_nw.consumer_write_address[1] = 8'h08;
    bus_nw.consumer_write_data[1] = 8'h44;
    repeat (4) begin
      tick();
      check("nw_mem_wr_valid", bus_nw.mem_write_valid, 0);
      check("nw_busy", busy_nw, 0);
      check("nw_wr_ready", bus_nw.consumer_write_ready, 0);
    end
    bus_nw.consumer_write_valid = '0;

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      bit any;
      int dummy_w;
      bit dummy_rd;
      for (int c = 0; c < N; c++) begin
        if (!req_rd[c] && $urandom_range(0, 3) == 0) set_rd(c, 8'($urandom));
        if (!req_wr[c] && $urandom_range(0, 3) == 0) set_wr(c, 8'($urandom), 8'($urandom));
      end
      dummy_w = pick(dummy_rd);
      any = (dummy_w >= 0);
      if (!any) set_rd(int'($urandom_range(0, N - 1)), 8'($urandom));
      serve_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                $urandom_range(0, 7) == 0, 8'($urandom));
    end
    for (int k = 0; k < 2 * N; k++) serve_one(0, 0, 1'b0, 8'($urandom));
    for (int c = 0; c < N; c++) check("final_rd_data", bus.consumer_read_data[c], rd_data_m[c]);

    // Reset while consumer 5 waits on memory
    set_rd(5, 8'h5A);
    tick();
    check("mid_grant_valid", bus.mem_read_valid, 1);
    check("mid_grant_owner", owner, 5);
    reset = 1'b1;
    tick();
    check("mid_rst_rd_valid", bus.mem_read_valid, 0);
    check("mid_rst_rd_ready", bus.consumer_read_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_owner", owner, 7);
    check("mid_rst_rd_addr", bus.mem_read_address, 0);
    reset = 1'b0;
    owner_m = N - 1;
    for (int c = 0; c < N; c++) rd_data_m[c] = '0;
    set_rd(0, 8'h01);
    serve_one(1, 0, 1'b0, 8'hC3);
    check("mid_after_owner0", owner, 0);
    serve_one(0, 0, 1'b0, 8'h3C);
    check("mid_after_owner5", owner, 5);
    check("mid_rd_data5", bus.consumer_read_data[5], 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
